// File: rtl/dm_ext.sv
// Byte-lane data memory for the MEM stage: sized stores, sign/zero-extended loads,
// alignment and range flags, and a one-word-per-cycle clear sweep after reset.
module dm_ext #(
    parameter int          DEPTH     = 3072,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          IDX_W     = 12
) (
    input  logic        Clk,
    input  logic        reset_n,
    input  logic [31:0] addr,
    input  logic [31:0] WD,
    input  logic        WE,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] D,
    output logic        busy,
    output logic        exc_align,
    output logic        exc_range
);

    localparam logic ST_CLEAR = 1'b0;
    localparam logic ST_READY = 1'b1;

    logic             state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;

    logic [32:0]      off;
    logic [IDX_W-1:0] acc_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [3:0]       lane_we;
    logic [31:0]      lane_wd;
    logic [31:0]      rd_word;
    logic             store_ok;
    logic             unused_off;

    // 33-bit offset so an address below BASE_ADDR cannot wrap into range.
    assign off        = {1'b0, addr} - {1'b0, BASE_ADDR};
    assign acc_idx    = off[IDX_W+1:2];
    assign unused_off = ^off[1:0];

    assign exc_range = (addr < BASE_ADDR) || (off[32:2] >= 31'(DEPTH));

    always_comb begin
        exc_align = 1'b0;
        case (size)
            2'b01:   exc_align = addr[0];
            2'b10:   exc_align = (addr[1:0] != 2'b00);
            2'b11:   exc_align = 1'b1;
            default: exc_align = 1'b0;
        endcase
    end

    assign busy     = (state_q == ST_CLEAR);
    assign store_ok = reset_n && !busy && WE && !exc_align && !exc_range;
    assign rd_idx   = exc_range ? '0 : acc_idx;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == ST_CLEAR) begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
                state_d = ST_READY;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Lane enables and right-aligned data replicated onto the addressed lanes.
    always_comb begin
        lane_we = 4'b0000;
        lane_wd = '0;
        wr_idx  = acc_idx;
        if (reset_n && busy) begin
            lane_we = 4'b1111;
            wr_idx  = clr_idx_q;
        end else if (store_ok) begin
            case (size)
                2'b00: begin
                    lane_we[addr[1:0]] = 1'b1;
                    lane_wd            = {4{WD[7:0]}};
                end
                2'b01: begin
                    lane_we = addr[1] ? 4'b1100 : 4'b0011;
                    lane_wd = {2{WD[15:0]}};
                end
                default: begin
                    lane_we = 4'b1111;
                    lane_wd = WD;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];

        always_ff @(posedge Clk) begin
            if (lane_we[gi]) begin
                lane_mem[wr_idx] <= lane_wd[8*gi +: 8];
            end
        end

        assign rd_word[8*gi +: 8] = lane_mem[rd_idx];
    end

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_byte = rd_word[8*addr[1:0] +: 8];
    assign rd_half = addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        D = '0;
        if (!busy && !exc_align && !exc_range) begin
            case (size)
                2'b00:   D = uns ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
                2'b01:   D = uns ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
                2'b10:   D = rd_word;
                default: D = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_ext.sv
// Randomised and directed bench for dm_ext against a word-array reference model
// with an explicit sweep counter.
module tb_dm_ext;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          IDX_W = 4;

    logic        Clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] WD = '0;
    logic        WE = 1'b0;
    logic [1:0]  size = 2'b10;
    logic        uns = 1'b0;
    logic [31:0] D;
    logic        busy, exc_align, exc_range;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_mem [DEPTH];
    bit          m_busy = 1'b1;
    int          m_cnt  = 0;

    dm_ext #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .IDX_W(IDX_W)) dut (
        .Clk(Clk), .reset_n(reset_n), .addr(addr), .WD(WD), .WE(WE),
        .size(size), .uns(uns), .D(D), .busy(busy),
        .exc_align(exc_align), .exc_range(exc_range)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit m_align(input logic [31:0] a, input logic [1:0] s);
        return (s == 2'd3) || (s == 2'd2 && a % 4 != 0) || (s == 2'd1 && a % 2 != 0);
    endfunction

    function automatic bit m_range(input logic [31:0] a);
        longint la = longint'(a);
        longint lb = longint'(BASE);
        return (la < lb) || ((la - lb) / 4 >= DEPTH);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] s, input logic u);
        logic [31:0] w;
        int          sh;
        logic [31:0] v;
        if (m_busy || m_align(a, s) || m_range(a)) return 32'h0;
        w  = m_mem[(a - BASE) / 4];
        sh = 8 * int'(a % 4);
        if (s == 2'd2) return w;
        if (s == 2'd0) begin
            v = (w >> sh) & 32'hFF;
            if (!u && v >= 32'h80) v = v - 32'h100;
        end else begin
            v = (w >> sh) & 32'hFFFF;
            if (!u && v >= 32'h8000) v = v - 32'h1_0000;
        end
        return v;
    endfunction

    task automatic m_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        int          i  = int'((a - BASE) / 4);
        int          sh = 8 * int'(a % 4);
        logic [31:0] mask;
        mask = (s == 2'd0) ? (32'hFF << sh) : (s == 2'd1) ? (32'hFFFF << sh) : 32'hFFFF_FFFF;
        m_mem[i] = (m_mem[i] & ~mask) | ((d << sh) & mask);
    endtask

    // Advance one edge; the model consumes the inputs present before the edge.
    task automatic tick();
        if (!reset_n) begin
            m_busy = 1'b1;
            m_cnt  = 0;
        end else if (m_busy) begin
            m_mem[m_cnt] = 32'h0;
            m_cnt++;
            if (m_cnt == DEPTH) m_busy = 1'b0;
        end else if (WE && !m_align(addr, size) && !m_range(addr)) begin
            m_store(addr, size, WD);
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".D"},     D,                    m_load(addr, size, uns));
        check({tag, ".align"}, 32'(exc_align),       32'(m_align(addr, size)));
        check({tag, ".range"}, 32'(exc_range),       32'(m_range(addr)));
        check({tag, ".busy"},  32'(busy),            32'(m_busy));
    endtask

    task automatic access(input string tag, input logic [31:0] a, input logic [1:0] s,
                          input logic u, input logic we, input logic [31:0] d);
        addr = a; size = s; uns = u; WE = we; WD = d;
        #1;
        $display("%s addr=%h size=%0d uns=%0d we=%0d wd=%h D=%h al=%0d rg=%0d",
                 tag, a, s, u, we, d, D, exc_align, exc_range);
        check_outputs(tag);
        tick();
        WE = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [1:0] s,
                      input logic u, input logic [31:0] exp);
        addr = a; size = s; uns = u; WE = 1'b0;
        #1;
        $display("%s addr=%h size=%0d uns=%0d D=%h", tag, a, s, u, D);
        check(tag, D, exp);
        check_outputs(tag);
    endtask

    // Hold a word store to BASE active throughout the sweep; it must be dropped.
    task automatic count_busy(input string tag);
        int n = 0;
        addr = BASE; size = 2'd2; uns = 1'b0; WE = 1'b1; WD = 32'hDEAD_BEEF;
        #1;
        while (busy === 1'b1 && n < 100) begin
            check_outputs(tag);
            n++;
            tick();
        end
        WE = 1'b0;
        $display("%s busy_cycles=%0d", tag, n);
        check({tag, ".len"}, 32'(n), 32'(DEPTH));
        rd({tag, ".we_dropped"}, BASE, 2'd2, 1'b0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'hFFFF_FFFF;

        // Power-up reset and first sweep.
        tick(); tick();
        check("reset.busy", 32'(busy), 32'h1);
        check("reset.D", D, 32'h0);
        reset_n = 1'b1;
        count_busy("sweep0");

        // Pre-load, then reset for two edges and confirm the clear.
        for (int i = 0; i < DEPTH; i++)
            access("preload", BASE + 32'(4 * i), 2'd2, 1'b0, 1'b1, $urandom);
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        count_busy("sweep1");
        for (int i = 0; i < DEPTH; i++)
            rd("zero", BASE + 32'(4 * i), 2'd2, 1'b0, 32'h0);

        // Word and byte.
        access("sw", BASE + 32'h10, 2'd2, 1'b0, 1'b1, 32'h1234_5678);
        access("sb", BASE + 32'h11, 2'd0, 1'b0, 1'b1, 32'h0000_00AB);
        rd("lw10",  BASE + 32'h10, 2'd2, 1'b0, 32'h1234_AB78);
        rd("lb11",  BASE + 32'h11, 2'd0, 1'b0, 32'hFFFF_FFAB);
        rd("lbu11", BASE + 32'h11, 2'd0, 1'b1, 32'h0000_00AB);

        // Halfword.
        access("sh", BASE + 32'h22, 2'd1, 1'b0, 1'b1, 32'h0000_8001);
        rd("lw20",  BASE + 32'h20, 2'd2, 1'b0, 32'h8001_0000);
        rd("lh22",  BASE + 32'h22, 2'd1, 1'b0, 32'hFFFF_8001);
        rd("lhu22", BASE + 32'h22, 2'd1, 1'b1, 32'h0000_8001);
        rd("lh20",  BASE + 32'h20, 2'd1, 1'b0, 32'h0);

        // Misaligned and reserved size.
        access("sw_mis", BASE + 32'h13, 2'd2, 1'b0, 1'b1, 32'hCAFE_F00D);
        check("sw_mis.align", 32'(exc_align), 32'h1);
        access("sh_mis", BASE + 32'h21, 2'd1, 1'b0, 1'b1, 32'h0000_7777);
        rd("lw10_keep", BASE + 32'h10, 2'd2, 1'b0, 32'h1234_AB78);
        rd("lw20_keep", BASE + 32'h20, 2'd2, 1'b0, 32'h8001_0000);
        rd("sz3", BASE + 32'h10, 2'd3, 1'b0, 32'h0);
        check("sz3.align", 32'(exc_align), 32'h1);

        // Range edges.
        access("sw_lo", 32'h0000_0FFC, 2'd2, 1'b0, 1'b1, 32'h1111_1111);
        check("sw_lo.range", 32'(exc_range), 32'h1);
        access("sw_hi", 32'h0000_1040, 2'd2, 1'b0, 1'b1, 32'h2222_2222);
        access("sw_top", 32'h0000_103C, 2'd2, 1'b0, 1'b1, 32'h3333_3333);
        rd("lw_top", 32'h0000_103C, 2'd2, 1'b0, 32'h3333_3333);
        check("lw_top.range", 32'(exc_range), 32'h0);
        rd("lw_base", BASE, 2'd2, 1'b0, 32'h0);
        rd("lw_wrap", 32'hFFFF_F000, 2'd2, 1'b0, 32'h0);

        // Mid-sweep reset.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        count_busy("midsweep");

        // Random traffic, mostly in range with some near the boundaries.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            case ($urandom_range(0, 7))
                0:       a = BASE - 32'($urandom_range(1, 8));
                1:       a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 8));
                2:       a = $urandom;
                default: a = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
            endcase
            access("rnd", a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dm_ext.md
# dm_ext

Parametrised data memory for the single-cycle CPU's MEM stage. It supports word, halfword and byte stores through byte-lane enables, and sign- or zero-extends halfword and byte loads. It flags misaligned and out-of-range accesses instead of silently aliasing them. After reset it clears its contents with a sequential sweep, one word per cycle, and holds `busy` high until the sweep finishes.

## Interface
Parameters:
- `DEPTH`, default 3072: number of 32-bit words.
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0.
- `IDX_W`, default 12: width of the word index; must satisfy 2^IDX_W >= DEPTH.

Ports:
- `Clk` input 1: the single clock; all state updates on its rising edge.
- `reset_n` input 1: reset, synchronous and active-low.
- `addr` input 32: byte address.
- `WD` input 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `WE` input 1: store request for the current cycle.
- `size` input 2: 00 byte, 01 half, 10 word, 11 reserved.
- `uns` input 1: 1 = zero-extend loads, 0 = sign-extend; ignored for word.
- `D` output 32: load data, extended, combinational from `addr`/`size`/`uns`.
- `busy` output 1: clear sweep in progress.
- `exc_align` output 1: current access misaligned or reserved size.
- `exc_range` output 1: current access outside [BASE_ADDR, BASE_ADDR+4*DEPTH).

## Operation
- Two states: CLEAR and READY.
- Reset behaviour:
  - `reset_n` low at a rising edge forces state CLEAR and sweep index `clr_idx` to 0.
  - No RAM write occurs during an edge with `reset_n` low.
- CLEAR state:
  - Each edge with `reset_n` high writes RAM[`clr_idx`] = 0 and increments `clr_idx`.
  - The edge that writes index DEPTH-1 moves the state to READY.
- READY state: no sweep activity; stays in READY until reset.
- Output `busy` = (state == CLEAR). Its reset value is 1.
- While `busy` is high:
  - `WE` is ignored.
  - `D` = 0.
  - `exc_align` and `exc_range` are still computed from the inputs.
- Word index = (`addr` - BASE_ADDR) >> 2. `exc_range` = (`addr` < BASE_ADDR) OR (index >= DEPTH), evaluated in 33-bit arithmetic so there is no wrap.
- `exc_align` is set when any of the following holds:
  - `size` = 01 and `addr`[0] = 1.
  - `size` = 10 and `addr`[1:0] != 0.
  - `size` = 11.
- Store: performed on the rising edge only when `WE`=1, state READY, `exc_align`=0 and `exc_range`=0. Byte lanes written:
  - byte: lane `addr`[1:0] gets `WD`[7:0].
  - half: lanes {`addr`[1],1} and {`addr`[1],0} get `WD`[15:0].
  - word: all four lanes get `WD`.
  - Unwritten lanes keep their old value.
- Load:
  - `D` selects the addressed byte or half of RAM[index] and extends it according to `uns`.
  - If `exc_align` or `exc_range` is set, `D` = 0.
- Outputs at reset: `busy`=1 and `D`=0. `exc_*` are combinational and have no reset value.

## Timing
- Read path:
  - Zero latency: `D` is valid in the same cycle as `addr`.
  - A store at edge N is visible on `D` after edge N; same-cycle read-during-write returns the old data.
- Clear duration: `reset_n` released before edge k means the sweep writes indexes 0..DEPTH-1 on edges k..k+DEPTH-1. `busy` falls after edge k+DEPTH-1, so there are exactly DEPTH busy cycles after release.
- Reset asserted mid-sweep: the sweep restarts from index 0 at the next high edge. Words already cleared are harmless to clear again.
- Reset asserted in READY: behaves as in CLEAR; contents become zero again only after the full sweep completes.
- A store request that coincides with the final sweep edge is dropped.
- Exceptions:
  - Pure combinational, one per access; no sticky state.
  - The CPU must squash or trap the access in that same cycle.

## Test plan
- Reset clear: pre-load words, assert `reset_n`=0 for 2 edges, release.
  - `busy`=1 for exactly DEPTH edges, then 0.
  - Every word reads 0; a `WE` issued during busy has no effect.
- Word and byte stores:
  - sw 0x12345678 @0x10, then sb `WD`=0xAB @0x11 → word 0x1234AB78.
  - lb @0x11 → 0xFFFFFFAB; lbu @0x11 → 0x000000AB.
- Halfword:
  - sh `WD`=0x8001 @0x22 → word[8] = 0x8001_0000 over a prior 0.
  - lh @0x22 → 0xFFFF8001; lhu → 0x00008001; lh @0x20 → 0.
- Misalignment:
  - sw @0x13 or sh @0x21 → `exc_align`=1, memory unchanged, `D`=0.
  - `size`=11 → `exc_align`=1.
- Range (BASE_ADDR=0x1000, DEPTH=16):
  - sw @0x0FFC and sw @0x1040 → `exc_range`=1, no write.
  - sw @0x103C succeeds and reads back.
- Mid-sweep reset (DEPTH=16): drop `reset_n` for 1 edge after 5 sweep edges → `busy` stays high for a further 16 edges after release.
